multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle main control FSM sequencing the MIPS datapath over a shared instruction/data memory port.
//  Decodes the IR (instr_out from the datapath) and drives the datapath control inputs state by state.
//  Stalls on a req/ready memory handshake. Supports R-type (add/sub/and/or/slt), lw, sw, beq and addi.
// PARAMETERS
//  TIMEOUT_CYCLES  16  mem_ready wait limit; used only when MC_CTRL_TIMEOUT_EN is defined
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   asynchronous reset, active-high
//  run            in   1   1 = keep executing; sampled at instruction boundaries
//  instr          in   32  current IR contents from the datapath
//  mem_ready      in   1   memory completed the request this cycle
//  mem_req        out  1   memory access request, held until mem_ready
//  pc_write_en    out  1   PC <= PC+4 (FETCH completion)
//  ir_write_en    out  1   IR <= fetched word (FETCH completion)
//  reg_write_en   out  1   register file write
//  reg_dst        out  1   0 = rt, 1 = rd
//  alu_src        out  1   0 = register, 1 = sign-extended immediate
//  alu_ctrl       out  3   010 add, 110 sub, 000 and, 001 or, 111 slt
//  mem_write_en   out  1   data memory write (sw)
//  mem_to_reg     out  1   0 = ALU result, 1 = memory data
//  branch         out  1   beq compare/commit cycle
//  retired        out  1   1-cycle pulse in the final state of each instruction
//  illegal        out  1   sticky; unsupported opcode/funct decoded
//  mem_timeout    out  1   sticky; tied 0 when MC_CTRL_TIMEOUT_EN is undefined
//  state_out      out  4   current state encoding, for debug
// BEHAVIOUR
//  Reset:
//   - rst forces IDLE immediately (asynchronous), including mid-instruction.
//   - All outputs are 0 while in reset, and in IDLE.
//  States (state_out):
//   IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6,
//   EXEC=7, ALUWB=8, BRANCH=9, ADDIEX=10, ADDIWB=11, TRAP=15.
//  Outputs are Moore decodes of state. Exceptions: pc_write_en and ir_write_en = (state==FETCH) & mem_ready.
//  Transitions and outputs:
//   - IDLE: -> FETCH when run=1.
//   - FETCH: mem_req=1; stay until mem_ready; then -> DECODE.
//   - DECODE: opcode instr[31:26] selects next state.
//     - 100011 or 101011 -> MEMADR; 000000 -> EXEC; 000100 -> BRANCH; 001000 -> ADDIEX.
//     - Any other opcode, or an R-type funct not in {100000, 100010, 100100, 100101, 101010} -> TRAP.
//   - MEMADR: alu_src=1, alu_ctrl=010. lw -> MEMRD; sw -> MEMWR.
//   - MEMRD: mem_req=1, alu_src=1, alu_ctrl=010; on mem_ready -> MEMWB.
//   - MEMWB: reg_write_en=1, mem_to_reg=1, reg_dst=0; retired=1.
//   - MEMWR: mem_req=1, mem_write_en=1, alu_src=1, alu_ctrl=010; on mem_ready: retired=1, instruction ends.
//   - EXEC: alu_src=0; alu_ctrl from funct (add 010, sub 110, and 000, or 001, slt 111).
//   - ALUWB: same alu_ctrl as EXEC, reg_write_en=1, reg_dst=1; retired=1.
//   - BRANCH: branch=1, alu_src=0, alu_ctrl=110; retired=1.
//   - ADDIEX: alu_src=1, alu_ctrl=010.
//   - ADDIWB: alu_src=1, alu_ctrl=010, reg_write_en=1, reg_dst=0; retired=1.
//   - Instruction end (any retiring state): -> FETCH if run=1, else -> IDLE.
//     run=0 mid-instruction does not abort the instruction.
//   - TRAP: illegal=1; all controls 0; leaves only on rst.
//  Latency with mem_ready=1 (FETCH through retire):
//   R-type 4 cycles; addi 4; beq 3; sw 4; lw 5.
//   Each cycle mem_ready is low adds one cycle.
//  mem_ready outside FETCH, MEMRD and MEMWR is ignored.
// CONFIGURATION
//  MC_CTRL_TIMEOUT_EN defined:
//   - A counter clears on entry to FETCH, MEMRD or MEMWR and increments each cycle mem_ready=0.
//   - When it reaches TIMEOUT_CYCLES: mem_timeout=1 (sticky), illegal stays 0, -> TRAP.
//  MC_CTRL_TIMEOUT_EN undefined: no counter; waits indefinitely; mem_timeout tied 0.
// TESTING
//  1. rst, run=1, mem_ready=1, instr=0x00221820 (add) -> states 1,2,7,8.
//     ALUWB: reg_write_en=1, reg_dst=1, alu_ctrl=010, retired=1; then FETCH.
//  2. instr=0x8C220004 (lw), mem_ready low 3 cycles in MEMRD -> mem_req high 4 cycles in MEMRD;
//     MEMWB: mem_to_reg=1, reg_write_en=1; 8 cycles total.
//  3. instr=0xAC220008 (sw), mem_ready=1 -> MEMWR: mem_write_en=1, mem_req=1, retired=1; reg_write_en never 1.
//  4. instr=0x10220003 (beq) -> BRANCH: branch=1, alu_ctrl=110, retired=1; 3 cycles.
//     Then run=0 -> IDLE, all outputs 0.
//  5. instr=0xFC000000 -> DECODE then TRAP: illegal=1, state_out=15, held through run toggles.
//     rst -> IDLE, illegal=0.
//  6. rst asserted mid-MEMWR -> mem_write_en and mem_req 0 in the same cycle, state_out=0.
//     With MC_CTRL_TIMEOUT_EN: mem_ready=0 for 16 cycles in FETCH -> mem_timeout=1, TRAP.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Bundle between the multi-cycle main control FSM and the datapath/memory it sequences.
// master = controller side, slave = datapath/memory side.
interface multicycle_ctrl_if;
    logic        run;
    logic [31:0] instr;
    logic        mem_ready;
    logic        mem_req;
    logic        pc_write_en;
    logic        ir_write_en;
    logic        reg_write_en;
    logic        reg_dst;
    logic        alu_src;
    logic [2:0]  alu_ctrl;
    logic        mem_write_en;
    logic        mem_to_reg;
    logic        branch;
    logic        retired;
    logic        illegal;
    logic        mem_timeout;
    logic [3:0]  state_out;

    // Handshake: mem_req stays high until the cycle mem_ready is seen; that cycle completes the access.
    modport master (
        input  run, instr, mem_ready,
        output mem_req, pc_write_en, ir_write_en, reg_write_en, reg_dst, alu_src,
               alu_ctrl, mem_write_en, mem_to_reg, branch, retired, illegal,
               mem_timeout, state_out
    );

    modport slave (
        output run, instr, mem_ready,
        input  mem_req, pc_write_en, ir_write_en, reg_write_en, reg_dst, alu_src,
               alu_ctrl, mem_write_en, mem_to_reg, branch, retired, illegal,
               mem_timeout, state_out
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM (R-type, lw, sw, beq, addi) over a shared memory port.
// Optional memory-wait watchdog enabled by defining MC_CTRL_TIMEOUT_EN.
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        EXEC   = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11,
        TRAP   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

`ifdef MC_CTRL_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t      state, next;
    logic [5:0]  opcode, funct;
    logic        unused_instr_bits;
    logic        wait_st, tmo_hit;
    logic [CW-1:0] tmo_cnt;
    logic        illegal_q, timeout_q;

    logic        mem_req, reg_write_en, reg_dst, alu_src, mem_write_en;
    logic        mem_to_reg, branch, retired;
    logic [2:0]  alu_ctrl;
    state_t      end_next;

    assign opcode            = bus.instr[31:26];
    assign funct             = bus.instr[5:0];
    assign unused_instr_bits = ^bus.instr[25:6];

    function automatic logic funct_ok(input logic [5:0] f);
        case (f)
            6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_ok = 1'b1;
            default:                                               funct_ok = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = 3'b000;
            6'b100101: funct_alu = 3'b001;
            6'b101010: funct_alu = 3'b111;
            default:   funct_alu = ALU_ADD;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    // Watchdog: cleared on every state change, counts consecutive mem_ready=0 cycles while waiting.
    assign wait_st = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
    assign tmo_hit = TMO_EN && wait_st && !bus.mem_ready && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

    if (TMO_EN) begin : g_tmo
        always_ff @(posedge clk or posedge rst) begin
            if (rst)                            tmo_cnt <= '0;
            else if (state != next)             tmo_cnt <= '0;
            else if (wait_st && !bus.mem_ready) tmo_cnt <= tmo_cnt + 1'b1;
        end
    end else begin : g_no_tmo
        assign tmo_cnt = '0;
    end

    assign end_next = bus.run ? FETCH : IDLE;

    always_comb begin
        next         = state;
        mem_req      = 1'b0;
        reg_write_en = 1'b0;
        reg_dst      = 1'b0;
        alu_src      = 1'b0;
        alu_ctrl     = 3'b000;
        mem_write_en = 1'b0;
        mem_to_reg   = 1'b0;
        branch       = 1'b0;
        retired      = 1'b0;
        case (state)
            IDLE:   if (bus.run) next = FETCH;
            FETCH: begin
                mem_req = 1'b1;
                if (bus.mem_ready) next = DECODE;
            end
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next = MEMADR;
                    OP_RTYPE:     next = funct_ok(funct) ? EXEC : TRAP;
                    OP_BEQ:       next = BRANCH;
                    OP_ADDI:      next = ADDIEX;
                    default:      next = TRAP;
                endcase
            end
            MEMADR: begin
                alu_src  = 1'b1;
                alu_ctrl = ALU_ADD;
                next     = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_req  = 1'b1;
                alu_src  = 1'b1;
                alu_ctrl = ALU_ADD;
                if (bus.mem_ready) next = MEMWB;
            end
            MEMWB: begin
                reg_write_en = 1'b1;
                mem_to_reg   = 1'b1;
                retired      = 1'b1;
                next         = end_next;
            end
            MEMWR: begin
                mem_req      = 1'b1;
                mem_write_en = 1'b1;
                alu_src      = 1'b1;
                alu_ctrl     = ALU_ADD;
                if (bus.mem_ready) begin
                    retired = 1'b1;
                    next    = end_next;
                end
            end
            EXEC:   begin
                alu_ctrl = funct_alu(funct);
                next     = ALUWB;
            end
            ALUWB: begin
                alu_ctrl     = funct_alu(funct);
                reg_write_en = 1'b1;
                reg_dst      = 1'b1;
                retired      = 1'b1;
                next         = end_next;
            end
            BRANCH: begin
                branch   = 1'b1;
                alu_ctrl = ALU_SUB;
                retired  = 1'b1;
                next     = end_next;
            end
            ADDIEX: begin
                alu_src  = 1'b1;
                alu_ctrl = ALU_ADD;
                next     = ADDIWB;
            end
            ADDIWB: begin
                alu_src      = 1'b1;
                alu_ctrl     = ALU_ADD;
                reg_write_en = 1'b1;
                retired      = 1'b1;
                next         = end_next;
            end
            TRAP:    next = TRAP;
            default: next = IDLE;
        endcase
        if (tmo_hit) next = TRAP;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (state == DECODE && next == TRAP) illegal_q <= 1'b1;
            if (tmo_hit)                         timeout_q <= 1'b1;
        end
    end

    assign bus.mem_req      = mem_req;
    assign bus.pc_write_en  = (state == FETCH) && bus.mem_ready;
    assign bus.ir_write_en  = (state == FETCH) && bus.mem_ready;
    assign bus.reg_write_en = reg_write_en;
    assign bus.reg_dst      = reg_dst;
    assign bus.alu_src      = alu_src;
    assign bus.alu_ctrl     = alu_ctrl;
    assign bus.mem_write_en = mem_write_en;
    assign bus.mem_to_reg   = mem_to_reg;
    assign bus.branch       = branch;
    assign bus.retired      = retired;
    assign bus.illegal      = illegal_q;
    assign bus.mem_timeout  = timeout_q & TMO_EN;
    assign bus.state_out    = state;

endmodule
